load_data_queue: RTL and testbench

LOAD_DATA_QUEUE -- requirements
Module: load_data_queue

---
 rtl/load_data_queue.sv | 226 ++++++++++++++++++++++
 tb/tb_load_data_queue.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_data_queue.sv
// Load data queue: holds in-flight loads from address issue until their data is
// assembled from store forwarding, cache hits and MSHR fills.
// Latency: at least 2 cycles from accept to out_valid (one lookup cycle, then DONE);
//   a load with an empty byte mask goes straight to DONE.
// Backpressure: in_ready drops when no entry is FREE; out_ready low holds DONE entries.
//
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   in_*                : load offered from the address stage (valid/ready)
//   lk_*                : lookup of the oldest-index PEND entry; sq_* / cache_* answer in the same cycle
//   fill_*              : MSHR fill broadcast
//   out_*               : completed load towards the load buffer (valid/ready)
//   br_resolve/mispred  : branch resolution (clear mask bit, or squash dependent loads)
module load_data_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_BYTES = 4,
  parameter int BM_W       = 4,
  parameter int TAG_W      = 6,
  parameter int SQ_W       = 3,
  parameter int MSHR_W     = 3,
  parameter int ADDR_W     = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [DATA_BYTES-1:0]   in_byte_mask,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic [2:0]              in_func,
  input  logic [BM_W-1:0]         in_bm,
  input  logic [SQ_W-1:0]         in_sq_tail,
  output logic                    lk_valid,
  output logic [ADDR_W-1:0]       lk_addr,
  output logic [SQ_W-1:0]         lk_sq_tail,
  input  logic [8*DATA_BYTES-1:0] sq_data,
  input  logic [DATA_BYTES-1:0]   sq_mask,
  input  logic                    cache_valid,
  input  logic [DATA_BYTES-1:0]   cache_mask,
  input  logic [8*DATA_BYTES-1:0] cache_data,
  input  logic [MSHR_W-1:0]       cache_mshr,
  input  logic                    fill_valid,
  input  logic [MSHR_W-1:0]       fill_mshr,
  input  logic [8*DATA_BYTES-1:0] fill_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TAG_W-1:0]        out_tag,
  output logic [2:0]              out_func,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [BM_W-1:0]         out_bm,
  output logic [8*DATA_BYTES-1:0] out_data,
  input  logic [BM_W-1:0]         br_resolve,
  input  logic                    br_mispred
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int DW    = 8 * DATA_BYTES;

  typedef enum logic [1:0] {
    S_FREE = 2'd0,
    S_PEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } st_e;

  // rem holds the bytes still missing; data starts at zero so bytes the load
  // never asked for stay zero all the way to out_data.
  typedef struct packed {
    st_e               st;
    logic [ADDR_W-1:0] addr;
    logic [DATA_BYTES-1:0] rem;
    logic [TAG_W-1:0]  tag;
    logic [2:0]        func;
    logic [BM_W-1:0]   bm;
    logic [SQ_W-1:0]   sq_tail;
    logic [MSHR_W-1:0] mshr;
    logic [DW-1:0]     data;
  } ent_t;

  ent_t ent_q [DEPTH];
  ent_t ent_d [DEPTH];

  // Copy the bytes of src selected by sel into dst.
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] dst,
                                                 input logic [DW-1:0] src,
                                                 input logic [DATA_BYTES-1:0] sel);
    logic [DW-1:0] r;
    r = dst;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (sel[b]) r[8*b +: 8] = src[8*b +: 8];
    end
    return r;
  endfunction

  logic [BM_W-1:0]       br_clr;
  logic [BM_W-1:0]       br_kill;
  logic [DEPTH-1:0]      free_v;
  logic [DEPTH-1:0]      pend_v;
  logic [DEPTH-1:0]      done_v;
  logic [DEPTH-1:0]      kill_v;
  logic [IDX_W-1:0]      alloc_idx;
  logic [IDX_W-1:0]      lk_idx;
  logic [IDX_W-1:0]      out_idx;
  logic                  alloc_fire;
  ent_t                  lk_ent;
  ent_t                  out_ent;
  logic [DATA_BYTES-1:0] sq_take;
  logic [DATA_BYTES-1:0] ca_take;
  logic [DATA_BYTES-1:0] lk_rem;
  logic [DW-1:0]         lk_data;
  logic                  lk_fill_hit;

  // Entry status vectors, selection and outputs.
  always_comb begin
    br_clr  = br_mispred ? '0 : br_resolve;
    br_kill = br_mispred ? br_resolve : '0;

    for (int i = 0; i < DEPTH; i++) begin
      // Stale masks of FREE slots must not count as squash hits.
      kill_v[i] = (ent_q[i].st != S_FREE) && (|(ent_q[i].bm & br_kill));
      free_v[i] = (ent_q[i].st == S_FREE);
      pend_v[i] = (ent_q[i].st == S_PEND) && !kill_v[i];
      done_v[i] = (ent_q[i].st == S_DONE) && !kill_v[i];
    end

    // Descending scans leave the lowest matching index.
    alloc_idx = '0;
    lk_idx    = '0;
    out_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_v[i]) alloc_idx = IDX_W'(i);
      if (pend_v[i]) lk_idx    = IDX_W'(i);
      if (done_v[i]) out_idx   = IDX_W'(i);
    end

    // in_ready looks only at registered state, so a slot freed this cycle
    // becomes usable next cycle.
    in_ready   = |free_v;
    alloc_fire = in_valid && in_ready && !(|(in_bm & br_kill));

    lk_valid   = |pend_v;
    lk_ent     = ent_q[lk_idx];
    lk_addr    = lk_valid ? lk_ent.addr : '0;
    lk_sq_tail = lk_valid ? lk_ent.sq_tail : '0;

    // Store forwarding wins over the cache byte-by-byte.
    sq_take     = lk_ent.rem & sq_mask;
    ca_take     = lk_ent.rem & ~sq_mask & (cache_valid ? cache_mask : '0);
    lk_data     = merge_bytes(merge_bytes(lk_ent.data, sq_data, sq_take), cache_data, ca_take);
    lk_rem      = lk_ent.rem & ~(sq_take | ca_take);
    lk_fill_hit = fill_valid && (cache_mshr == fill_mshr);

    out_valid = |done_v;
    out_ent   = ent_q[out_idx];
    out_tag   = out_valid ? out_ent.tag : '0;
    out_func  = out_valid ? out_ent.func : '0;
    out_addr  = out_valid ? out_ent.addr : '0;
    out_bm    = out_valid ? (out_ent.bm & ~br_clr) : '0;
    out_data  = out_valid ? out_ent.data : '0;
  end

  // Per-entry next state.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i]    = ent_q[i];
      ent_d[i].bm = ent_q[i].bm & ~br_clr;

      case (ent_q[i].st)
        S_PEND: begin
          if (lk_valid && (lk_idx == IDX_W'(i))) begin
            ent_d[i].data = lk_data;
            ent_d[i].rem  = lk_rem;
            if (lk_rem == '0) begin
              ent_d[i].st = S_DONE;
            end else if (cache_valid) begin
              ent_d[i].mshr = cache_mshr;
              // The fill for the MSHR just handed out may arrive this very cycle.
              if (lk_fill_hit) begin
                ent_d[i].data = merge_bytes(lk_data, fill_data, lk_rem);
                ent_d[i].rem  = '0;
                ent_d[i].st   = S_DONE;
              end else begin
                ent_d[i].st = S_WAIT;
              end
            end
            // Otherwise the lookup was refused: stay PEND keeping forwarded bytes.
          end
        end
        S_WAIT: begin
          if (fill_valid && (ent_q[i].mshr == fill_mshr)) begin
            ent_d[i].data = merge_bytes(ent_q[i].data, fill_data, ent_q[i].rem);
            ent_d[i].rem  = '0;
            ent_d[i].st   = S_DONE;
          end
        end
        S_DONE: begin
          if (out_valid && out_ready && (out_idx == IDX_W'(i))) ent_d[i].st = S_FREE;
        end
        default: ;
      endcase

      if (kill_v[i]) ent_d[i].st = S_FREE;

      if (alloc_fire && (alloc_idx == IDX_W'(i))) begin
        ent_d[i].st      = (in_byte_mask == '0) ? S_DONE : S_PEND;
        ent_d[i].addr    = in_addr;
        ent_d[i].rem     = in_byte_mask;
        ent_d[i].tag     = in_tag;
        ent_d[i].func    = in_func;
        ent_d[i].bm      = in_bm & ~br_clr;
        ent_d[i].sq_tail = in_sq_tail;
        ent_d[i].mshr    = '0;
        ent_d[i].data    = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_load_data_queue.sv
// Bench for load_data_queue: directed loads with a tag-keyed scoreboard of
// expected completions, plus direct checks of handshake and latency points.
module tb_load_data_queue;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [3:0]  in_byte_mask;
  logic [5:0]  in_tag;
  logic [2:0]  in_func;
  logic [3:0]  in_bm;
  logic [2:0]  in_sq_tail;
  logic        lk_valid;
  logic [31:0] lk_addr;
  logic [2:0]  lk_sq_tail;
  logic [31:0] sq_data;
  logic [3:0]  sq_mask;
  logic        cache_valid;
  logic [3:0]  cache_mask;
  logic [31:0] cache_data;
  logic [2:0]  cache_mshr;
  logic        fill_valid;
  logic [2:0]  fill_mshr;
  logic [31:0] fill_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_tag;
  logic [2:0]  out_func;
  logic [31:0] out_addr;
  logic [3:0]  out_bm;
  logic [31:0] out_data;
  logic [3:0]  br_resolve;
  logic        br_mispred;

  // Manual cache response, or an automatic full-hit model keyed on lk_addr.
  logic        auto_cache;
  logic        man_cv;
  logic [3:0]  man_cm;
  logic [31:0] man_cd;
  logic [2:0]  man_mshr;

  always_comb begin
    cache_valid = man_cv;
    cache_mask  = man_cm;
    cache_data  = man_cd;
    cache_mshr  = man_mshr;
    if (auto_cache) begin
      cache_valid = lk_valid;
      cache_mask  = 4'hF;
      cache_data  = lk_addr ^ 32'hA5A5_0000;
      cache_mshr  = 3'd0;
    end
  end

  load_data_queue dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_byte_mask(in_byte_mask), .in_tag(in_tag), .in_func(in_func),
    .in_bm(in_bm), .in_sq_tail(in_sq_tail),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_sq_tail(lk_sq_tail),
    .sq_data(sq_data), .sq_mask(sq_mask),
    .cache_valid(cache_valid), .cache_mask(cache_mask), .cache_data(cache_data),
    .cache_mshr(cache_mshr),
    .fill_valid(fill_valid), .fill_mshr(fill_mshr), .fill_data(fill_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_func(out_func), .out_addr(out_addr), .out_bm(out_bm), .out_data(out_data),
    .br_resolve(br_resolve), .br_mispred(br_mispred)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  tag;
    logic [2:0]  func;
    logic [31:0] addr;
    logic [3:0]  bm;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic expect_out(input logic [5:0] t, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] d);
    exp_t e;
    e.tag = t; e.func = t[2:0]; e.addr = a; e.bm = b; e.data = d;
    sb.push_back(e);
  endtask

  // Completed loads may leave in index order, so match on tag.
  always @(negedge clock) begin
    int idx;
    if (reset && out_valid && out_ready) begin
      idx = -1;
      foreach (sb[k]) if (idx < 0 && sb[k].tag == out_tag) idx = k;
      chk("sb_tag_known", 64'(idx >= 0), 64'd1);
      if (idx >= 0) begin
        chk("sb_data", 64'(out_data), 64'(sb[idx].data));
        chk("sb_addr", 64'(out_addr), 64'(sb[idx].addr));
        chk("sb_func", 64'(out_func), 64'(sb[idx].func));
        chk("sb_bm",   64'(out_bm),   64'(sb[idx].bm));
        sb.delete(idx);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_addr = '0; in_byte_mask = '0; in_tag = '0; in_func = '0;
    in_bm = '0; in_sq_tail = '0; sq_data = '0; sq_mask = '0;
    man_cv = 0; man_cm = '0; man_cd = '0; man_mshr = '0;
    fill_valid = 0; fill_mshr = '0; fill_data = '0;
    br_resolve = '0; br_mispred = 0;
  endtask

  // Offer one load for one cycle; returns one edge later with in_valid low.
  task automatic issue(input logic [31:0] a, input logic [3:0] m, input logic [5:0] t,
                       input logic [3:0] b, input logic [2:0] sqt);
    in_valid = 1; in_addr = a; in_byte_mask = m; in_tag = t; in_func = t[2:0];
    in_bm = b; in_sq_tail = sqt;
    #1 chk("in_ready_on_issue", 64'(in_ready), 64'd1);
    step();
    in_valid = 0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 30 && sb.size() != 0; k++) step();
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 0; out_ready = 1; auto_cache = 0;
    idle();
    step(); step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_lk_valid", 64'(lk_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_lk_addr", 64'(lk_addr), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    reset = 1;
    step();

    // Full hit, 2-cycle latency; correct branch resolve clears out_bm same cycle.
    expect_out(6'd1, 32'h100, 4'b0010, 32'hDEADBEEF);
    issue(32'h100, 4'hF, 6'd1, 4'b0011, 3'd0);
    man_cv = 1; man_cm = 4'hF; man_cd = 32'hDEADBEEF;
    #1 chk("hit_lk_valid", 64'(lk_valid), 64'd1);
    chk("hit_lk_addr", 64'(lk_addr), 64'h100);
    chk("hit_out_early", 64'(out_valid), 64'd0);
    step();
    idle();
    br_resolve = 4'b0001; br_mispred = 0;
    #1 chk("hit_out_valid", 64'(out_valid), 64'd1);
    chk("hit_out_bm", 64'(out_bm), 64'b0010);
    step();
    idle();
    #1 chk("hit_out_gone", 64'(out_valid), 64'd0);

    // Store-forward merge with cache.
    expect_out(6'd2, 32'h104, 4'd0, 32'h1234AAAA);
    issue(32'h104, 4'hF, 6'd2, 4'd0, 3'd5);
    sq_mask = 4'b0011; sq_data = 32'h0000AAAA;
    man_cv = 1; man_cm = 4'hF; man_cd = 32'h12345678;
    #1 chk("merge_lk_sq_tail", 64'(lk_sq_tail), 64'd5);
    step();
    idle();
    drain("merge_drain");

    // Unneeded bytes come out zero.
    expect_out(6'd3, 32'h108, 4'd0, 32'h00FF00FF);
    issue(32'h108, 4'b0101, 6'd3, 4'd0, 3'd0);
    man_cv = 1; man_cm = 4'hF; man_cd = 32'hFFFFFFFF;
    step();
    idle();
    drain("partial_drain");

    // Refused lookup keeps forwarded bytes and retries.
    expect_out(6'd4, 32'h10C, 4'd0, 32'h112233EE);
    issue(32'h10C, 4'hF, 6'd4, 4'd0, 3'd0);
    sq_mask = 4'b0001; sq_data = 32'h000000EE;
    step();
    idle();
    #1 chk("retry_lk_valid", 64'(lk_valid), 64'd1);
    man_cv = 1; man_cm = 4'hF; man_cd = 32'h11223344;
    step();
    idle();
    drain("retry_drain");

    // Miss then fill; wrong MSHR ignored.
    expect_out(6'd5, 32'h200, 4'd0, 32'hCAFEF00D);
    issue(32'h200, 4'hF, 6'd5, 4'd0, 3'd0);
    man_cv = 1; man_cm = 4'h0; man_mshr = 3'd2;
    step();
    idle();
    #1 chk("miss_lk_idle", 64'(lk_valid), 64'd0);
    chk("miss_out_idle", 64'(out_valid), 64'd0);
    fill_valid = 1; fill_mshr = 3'd3; fill_data = 32'h11111111;
    step();
    idle();
    #1 chk("miss_wrong_mshr", 64'(out_valid), 64'd0);
    step();
    fill_valid = 1; fill_mshr = 3'd2; fill_data = 32'hCAFEF00D;
    step();
    idle();
    #1 chk("miss_out_valid", 64'(out_valid), 64'd1);
    chk("miss_out_data", 64'(out_data), 64'hCAFEF00D);
    step();

    // Partial cache hit whose MSHR fill lands in the same cycle.
    expect_out(6'd6, 32'h204, 4'd0, 32'hAABB1234);
    issue(32'h204, 4'hF, 6'd6, 4'd0, 3'd0);
    man_cv = 1; man_cm = 4'b1100; man_cd = 32'hAABB0000; man_mshr = 3'd6;
    fill_valid = 1; fill_mshr = 3'd6; fill_data = 32'h55661234;
    step();
    idle();
    drain("samecyc_drain");

    // Empty byte mask completes with zero data.
    expect_out(6'd7, 32'h208, 4'd0, 32'h0);
    issue(32'h208, 4'h0, 6'd7, 4'd0, 3'd0);
    drain("zero_mask_drain");

    // Fill the queue with out_ready low, then release one.
    out_ready = 0; auto_cache = 1;
    for (int t = 0; t < 4; t++) begin
      expect_out(6'(10 + t), 32'h1000 + 32'(4 * t), 4'd0, (32'h1000 + 32'(4 * t)) ^ 32'hA5A5_0000);
      issue(32'h1000 + 32'(4 * t), 4'hF, 6'(10 + t), 4'd0, 3'd0);
    end
    #1 chk("full_in_ready", 64'(in_ready), 64'd0);
    step(); step();
    chk("full_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1;
    #1 chk("full_same_cycle", 64'(in_ready), 64'd0);
    step();
    out_ready = 0;
    #1 chk("full_next_cycle", 64'(in_ready), 64'd1);
    out_ready = 1; auto_cache = 0;
    drain("full_drain");

    // Squash: A(bm 0001) and B(bm 0010) both waiting on MSHR 1.
    issue(32'h400, 4'hF, 6'd20, 4'b0001, 3'd0);
    man_cv = 1; man_cm = 4'h0; man_mshr = 3'd1;
    issue(32'h404, 4'hF, 6'd21, 4'b0010, 3'd0);
    step();
    idle();
    #1 chk("sq_both_wait", 64'(lk_valid), 64'd0);
    br_resolve = 4'b0001; br_mispred = 1;
    in_valid = 1; in_addr = 32'h408; in_byte_mask = 4'hF; in_tag = 6'd22; in_bm = 4'b0001;
    step();
    idle();
    #1 chk("sq_incoming_dropped", 64'(lk_valid), 64'd0);
    br_resolve = 4'b0010; br_mispred = 0;
    step();
    idle();
    expect_out(6'd21, 32'h404, 4'd0, 32'h77778888);
    fill_valid = 1; fill_mshr = 3'd1; fill_data = 32'h77778888;
    step();
    idle();
    #1 chk("sq_survivor_out", 64'(out_valid), 64'd1);
    chk("sq_survivor_tag", 64'(out_tag), 64'd21);
    step();
    #1 chk("sq_victim_gone", 64'(out_valid), 64'd0);

    // Asynchronous reset with one load waiting and one pending.
    man_cv = 1; man_cm = 4'h0; man_mshr = 3'd4;
    issue(32'h600, 4'hF, 6'd30, 4'd0, 3'd0);
    step();
    idle();
    issue(32'h604, 4'hF, 6'd31, 4'd0, 3'd0);
    #1 chk("rst2_lk_before", 64'(lk_valid), 64'd1);
    reset = 0;
    #1 chk("rst2_lk_now", 64'(lk_valid), 64'd0);
    chk("rst2_out_now", 64'(out_valid), 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    step();
    reset = 1;
    fill_valid = 1; fill_mshr = 3'd4; fill_data = 32'h99999999;
    step();
    idle();
    #1 chk("rst2_no_fill_out", 64'(out_valid), 64'd0);
    chk("rst2_no_lookup", 64'(lk_valid), 64'd0);
    step();
    chk("rst2_still_idle", 64'(out_valid), 64'd0);

    chk("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
